// File: rtl/lfsr.sv
// rtl/lfsr.sv - free-running maximal-length Fibonacci LFSR with seed load during reset
//
// Purpose: pseudo-random / test-sequence source. While reset_n is low the
// state follows init; after release the state advances one step per rising
// clock with period 2**N-1 over the nonzero values.
//
// Parameters:
//   N        state/output width, 2..64 (anything else fails elaboration)
//
// Ports:
//   clock    in   1   rising-edge clock
//   reset_n  in   1   asynchronous active-low reset; loads init
//   init     in   N   seed, sampled continuously during reset; must be nonzero
//   out      out  N   current LFSR state (registered)
//
// Optional feature macro: LFSR_ZERO_GUARD_EN
//   defined   - an all-zero next state is replaced by N'(1)
//   undefined - no guard; the zero state is absorbing

module lfsr #(
    parameter int N = 9
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] init,
    output logic [N-1:0] out
);

    if (N < 2 || N > 64) begin : g_bad_width
        $error("lfsr: N=%0d outside supported range 2..64", N);
    end

    // One-hot mask for tap position k (1-based, as in the tap table).
    function automatic logic [63:0] tb(input int k);
        return 64'd1 << (k - 1);
    endfunction

    // Tap sets of primitive polynomials, one per width.
    function automatic logic [63:0] tap_mask(input int n);
        logic [63:0] m;
        m = '0;
        case (n)
            2:  m = tb(2)  | tb(1);
            3:  m = tb(3)  | tb(2);
            4:  m = tb(4)  | tb(3);
            5:  m = tb(5)  | tb(3);
            6:  m = tb(6)  | tb(5);
            7:  m = tb(7)  | tb(6);
            8:  m = tb(8)  | tb(6)  | tb(5)  | tb(4);
            9:  m = tb(9)  | tb(5);
            10: m = tb(10) | tb(7);
            11: m = tb(11) | tb(9);
            12: m = tb(12) | tb(6)  | tb(4)  | tb(1);
            13: m = tb(13) | tb(4)  | tb(3)  | tb(1);
            14: m = tb(14) | tb(5)  | tb(3)  | tb(1);
            15: m = tb(15) | tb(14);
            16: m = tb(16) | tb(15) | tb(13) | tb(4);
            17: m = tb(17) | tb(14);
            18: m = tb(18) | tb(11);
            19: m = tb(19) | tb(6)  | tb(2)  | tb(1);
            20: m = tb(20) | tb(17);
            21: m = tb(21) | tb(19);
            22: m = tb(22) | tb(21);
            23: m = tb(23) | tb(18);
            24: m = tb(24) | tb(23) | tb(22) | tb(17);
            25: m = tb(25) | tb(22);
            26: m = tb(26) | tb(6)  | tb(2)  | tb(1);
            27: m = tb(27) | tb(5)  | tb(2)  | tb(1);
            28: m = tb(28) | tb(25);
            29: m = tb(29) | tb(27);
            30: m = tb(30) | tb(6)  | tb(4)  | tb(1);
            31: m = tb(31) | tb(28);
            32: m = tb(32) | tb(22) | tb(2)  | tb(1);
            33: m = tb(33) | tb(20);
            34: m = tb(34) | tb(27) | tb(2)  | tb(1);
            35: m = tb(35) | tb(33);
            36: m = tb(36) | tb(25);
            37: m = tb(37) | tb(5)  | tb(4)  | tb(3) | tb(2) | tb(1);
            38: m = tb(38) | tb(6)  | tb(5)  | tb(1);
            39: m = tb(39) | tb(35);
            40: m = tb(40) | tb(38) | tb(21) | tb(19);
            41: m = tb(41) | tb(38);
            42: m = tb(42) | tb(41) | tb(20) | tb(19);
            43: m = tb(43) | tb(42) | tb(38) | tb(37);
            44: m = tb(44) | tb(43) | tb(18) | tb(17);
            45: m = tb(45) | tb(44) | tb(42) | tb(41);
            46: m = tb(46) | tb(45) | tb(26) | tb(25);
            47: m = tb(47) | tb(42);
            48: m = tb(48) | tb(47) | tb(21) | tb(20);
            49: m = tb(49) | tb(40);
            50: m = tb(50) | tb(49) | tb(24) | tb(23);
            51: m = tb(51) | tb(50) | tb(36) | tb(35);
            52: m = tb(52) | tb(49);
            53: m = tb(53) | tb(52) | tb(38) | tb(37);
            54: m = tb(54) | tb(53) | tb(18) | tb(17);
            55: m = tb(55) | tb(31);
            56: m = tb(56) | tb(55) | tb(35) | tb(34);
            57: m = tb(57) | tb(50);
            58: m = tb(58) | tb(39);
            59: m = tb(59) | tb(58) | tb(38) | tb(37);
            60: m = tb(60) | tb(59);
            61: m = tb(61) | tb(60) | tb(46) | tb(45);
            62: m = tb(62) | tb(61) | tb(6)  | tb(5);
            63: m = tb(63) | tb(62);
            64: m = tb(64) | tb(63) | tb(61) | tb(60);
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [63:0]  TAP_MASK = tap_mask(N);
    localparam logic [N-1:0] TAPS     = TAP_MASK[N-1:0];

    logic         fb;
    logic [N-1:0] shifted;
    logic [N-1:0] next_state;

    always_comb begin
        fb      = ^(out & TAPS);
        shifted = {out[N-2:0], fb};
`ifdef LFSR_ZERO_GUARD_EN
        // Escape the absorbing zero state (zero seed or upset) in one step.
        next_state = (shifted == '0) ? N'(1) : shifted;
`else
        next_state = shifted;
`endif
    end

    // init reaches out only through the asynchronous reset load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out <= init;
        end else begin
            out <= next_state;
        end
    end

endmodule

// File: tb/tb_lfsr.sv
// tb/tb_lfsr.sv - directed self-checking bench for lfsr

module tb_lfsr;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  init9 = 9'h001;
    logic [16:0] init17 = 17'h00001;
    logic [32:0] init33 = 33'h1;
    logic [63:0] init64 = 64'h1;
    logic [8:0]  out9;
    logic [16:0] out17;
    logic [32:0] out33;
    logic [63:0] out64;

    int checks = 0;
    int failures = 0;

    lfsr #(.N(9))  u_dut9  (.clock(clock), .reset_n(reset_n), .init(init9),  .out(out9));
    lfsr #(.N(17)) u_dut17 (.clock(clock), .reset_n(reset_n), .init(init17), .out(out17));
    lfsr #(.N(33)) u_dut33 (.clock(clock), .reset_n(reset_n), .init(init33), .out(out33));
    lfsr #(.N(64)) u_dut64 (.clock(clock), .reset_n(reset_n), .init(init64), .out(out64));

    always #5 clock = ~clock;

    typedef struct {
        logic [8:0] seed;
        int         clocks;
        logic [8:0] exp_out;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    logic seen[512];
    int   dups;
    int   zeros;
    int   nonzero_cnt;

    initial begin
        vecs[0] = '{9'h001, 0, 9'h001};
        vecs[1] = '{9'h001, 1, 9'h002};
        vecs[2] = '{9'h001, 4, 9'h010};
        vecs[3] = '{9'h001, 5, 9'h021};
        vecs[4] = '{9'h0A5, 1, 9'h14A};
        vecs[5] = '{9'h0A5, 2, 9'h095};
        vecs[6] = '{9'h1FF, 1, 9'h1FE};
        vecs[7] = '{9'h1FF, 2, 9'h1FC};
        vecs[8] = '{9'h100, 1, 9'h001};
        vecs[9] = '{9'h010, 1, 9'h021};

        // Reset state and wide-width tap checks from seed 1.
        step(2);
        check("reset_out9", out9, 64'h001);
        check("reset_out64", out64, 64'h1);
        reset_n = 1'b1;
        step(14);
        check("n17_step14", out17, 64'h04001);
        step(6);
        check("n33_step20", out33, (64'h1 << 20) | 64'h1);
        step(40);
        check("n64_step60", out64, (64'h1 << 60) | 64'h1);

        // Table-driven vectors; each starts from an asynchronous reset load.
        foreach (vecs[i]) begin
            reset_n = 1'b0;
            init9   = vecs[i].seed;
            #1;
            check($sformatf("vec%0d_load", i), out9, 64'(vecs[i].seed));
            step(1);
            reset_n = 1'b1;
            step(vecs[i].clocks);
            check($sformatf("vec%0d_out", i), out9, 64'(vecs[i].exp_out));
        end

        // Full period for N=9 from seed 1.
        reset_n = 1'b0;
        init9   = 9'h001;
        step(1);
        reset_n = 1'b1;
        foreach (seen[i]) seen[i] = 1'b0;
        seen[1] = 1'b1;
        dups = 0;
        zeros = 0;
        for (int k = 0; k < 510; k++) begin
            step(1);
            if (out9 == 9'h000) zeros++;
            if (seen[out9]) dups++;
            seen[out9] = 1'b1;
        end
        check("period_dups", 64'(dups), 64'd0);
        check("period_zeros", 64'(zeros), 64'd0);
        step(1);
        check("period_wrap", out9, 64'h001);

        // Reset pulsed mid-run: asynchronous load, then restart from the seed.
        step(7);
        #2;
        init9   = 9'h0A5;
        reset_n = 1'b0;
        #1;
        check("midrun_async_load", out9, 64'h0A5);
        step(1);
        check("midrun_hold", out9, 64'h0A5);
        reset_n = 1'b1;
        step(1);
        check("midrun_restart1", out9, 64'h14A);
        step(1);
        check("midrun_restart2", out9, 64'h095);

        // Zero seed.
        reset_n = 1'b0;
        init9   = 9'h000;
        #1;
        check("zero_load", out9, 64'h000);
        step(1);
        reset_n = 1'b1;
        step(1);
`ifdef LFSR_ZERO_GUARD_EN
        check("zero_guard_first", out9, 64'h001);
        step(1);
        check("zero_guard_second", out9, 64'h002);
`else
        check("zero_first", out9, 64'h000);
        nonzero_cnt = 0;
        for (int k = 0; k < 19; k++) begin
            step(1);
            if (out9 != 9'h000) nonzero_cnt++;
        end
        check("zero_absorbing_20", 64'(nonzero_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
